// File: rtl/imu_yaw_reader.sv
// Command sequencer for the IMU behind the SPI monarch: power-up wait, three config
// writes, then a low/high yaw-rate read pair for every data-ready interrupt.
module imu_yaw_reader #(
    parameter int unsigned TMR_W = 16,
    parameter logic [15:0] CFG0  = 16'h0D02,
    parameter logic [15:0] CFG1  = 16'h1160,
    parameter logic [15:0] CFG2  = 16'h1440,
    parameter logic [15:0] RD_L  = 16'hA600,
    parameter logic [15:0] RD_H  = 16'hA700
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] resp,
    output logic        snd,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    typedef enum logic [2:0] {
        PWRUP = 3'd0,
        W0    = 3'd1,
        W1    = 3'd2,
        W2    = 3'd3,
        IDLE  = 3'd4,
        RL    = 3'd5,
        RH    = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_int_m;
    logic               r_int_s;
    logic               r_done_q;
    logic               w_cmpl;
    logic [TMR_W-1:0]   r_tmr;
    logic               w_tmr_full;
    logic [7:0]         r_yl;
    logic [7:0]         w_yl_nxt;
    logic               r_snd;
    logic               w_snd_nxt;
    logic [15:0]        r_cmd;
    logic [15:0]        w_cmd_nxt;
    logic [15:0]        r_yaw;
    logic [15:0]        w_yaw_nxt;
    logic               r_vld;
    logic               w_vld_nxt;
    logic               w_unused_resp_hi;

    // A done level left over from the previous transaction is not a completion.
    assign w_cmpl           = done & ~r_done_q;
    assign w_tmr_full       = &r_tmr;
    assign w_unused_resp_hi = ^resp[15:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_m  <= 1'b0;
            r_int_s  <= 1'b0;
            r_done_q <= 1'b0;
            r_tmr    <= '0;
        end else begin
            r_int_m  <= INT;
            r_int_s  <= r_int_m;
            r_done_q <= done;
            if (r_state == PWRUP) begin
                r_tmr <= r_tmr + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PWRUP;
            r_snd   <= 1'b0;
            r_cmd   <= '0;
            r_yaw   <= '0;
            r_vld   <= 1'b0;
            r_yl    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_snd   <= w_snd_nxt;
            r_cmd   <= w_cmd_nxt;
            r_yaw   <= w_yaw_nxt;
            r_vld   <= w_vld_nxt;
            r_yl    <= w_yl_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_snd_nxt   = 1'b0;
        w_cmd_nxt   = r_cmd;
        w_yaw_nxt   = r_yaw;
        w_vld_nxt   = 1'b0;
        w_yl_nxt    = r_yl;
        case (r_state)
            PWRUP: begin
                if (w_tmr_full) begin
                    w_cmd_nxt   = CFG0;
                    w_snd_nxt   = 1'b1;
                    w_state_nxt = W0;
                end
            end
            W0: begin
                if (w_cmpl) begin
                    w_cmd_nxt   = CFG1;
                    w_snd_nxt   = 1'b1;
                    w_state_nxt = W1;
                end
            end
            W1: begin
                if (w_cmpl) begin
                    w_cmd_nxt   = CFG2;
                    w_snd_nxt   = 1'b1;
                    w_state_nxt = W2;
                end
            end
            W2: begin
                if (w_cmpl) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (r_int_s) begin
                    w_cmd_nxt   = RD_L;
                    w_snd_nxt   = 1'b1;
                    w_state_nxt = RL;
                end
            end
            RL: begin
                if (w_cmpl) begin
                    w_yl_nxt    = resp[7:0];
                    w_cmd_nxt   = RD_H;
                    w_snd_nxt   = 1'b1;
                    w_state_nxt = RH;
                end
            end
            RH: begin
                // A still-high interrupt is picked up from IDLE on the next cycle.
                if (w_cmpl) begin
                    w_yaw_nxt   = {resp[7:0], r_yl};
                    w_vld_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = PWRUP;
            end
        endcase
    end

    assign snd    = r_snd;
    assign cmd    = r_cmd;
    assign yaw_rt = r_yaw;
    assign vld    = r_vld;

endmodule

// File: tb/tb_imu_yaw_reader.sv
// Directed bench for imu_yaw_reader: power-up timing, config writes, read pairs,
// held interrupt, stale done and reset mid-read against a hand-driven monarch.
module tb_imu_yaw_reader;

    logic        clk;
    logic        rst_n;
    logic        INT;
    logic        done;
    logic [15:0] resp;
    logic        snd;
    logic [15:0] cmd;
    logic [15:0] yaw_rt;
    logic        vld;

    int unsigned n_vec;
    int unsigned n_err;

    imu_yaw_reader #(.TMR_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .INT    (INT),
        .done   (done),
        .resp   (resp),
        .snd    (snd),
        .cmd    (cmd),
        .yaw_rt (yaw_rt),
        .vld    (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_snd(input string tag, input int budget);
        int n;
        n = 0;
        while (snd !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, ":snd"}, 16'(snd), 16'd1);
    endtask

    // Called at the falling edge of a snd cycle; completes that transaction.
    task automatic serve(input string tag, input logic [15:0] c, input logic [7:0] rb,
                         input int lat, input bit stale);
        chk({tag, ":cmd"}, cmd, c);
        if (stale) begin
            tick();
            chk({tag, ":stale_snd"}, 16'(snd), 16'd0);
            chk({tag, ":stale_cmd"}, cmd, c);
        end
        done = 1'b0;
        for (int i = 0; i < lat; i++) begin
            tick();
            chk({tag, ":busy_snd"}, 16'(snd), 16'd0);
            chk({tag, ":busy_cmd"}, cmd, c);
        end
        resp = {8'hA5, rb};
        done = 1'b1;
    endtask

    task automatic pwrup_and_config(input string tag, input int lat);
        for (int c = 1; c < 16; c++) begin
            tick();
            chk({tag, ":pre_snd"}, 16'(snd), 16'd0);
            chk({tag, ":pre_cmd"}, cmd, 16'h0000);
            chk({tag, ":pre_vld"}, 16'(vld), 16'd0);
        end
        tick();
        chk({tag, ":first_snd"}, 16'(snd), 16'd1);
        serve({tag, ":cfg0"}, 16'h0D02, 8'h00, lat, 1'b0);
        tick();
        chk({tag, ":cfg1_snd"}, 16'(snd), 16'd1);
        serve({tag, ":cfg1"}, 16'h1160, 8'h00, lat, 1'b1);
        tick();
        chk({tag, ":cfg2_snd"}, 16'(snd), 16'd1);
        serve({tag, ":cfg2"}, 16'h1440, 8'h00, lat, 1'b0);
        tick();
        chk({tag, ":w2_done_snd"}, 16'(snd), 16'd0);
    endtask

    logic [7:0]  lo_b [3];
    logic [7:0]  hi_b [3];
    logic [15:0] yaw_e [3];

    initial begin
        n_vec = 0;
        n_err = 0;
        lo_b  = '{8'h01, 8'hCD, 8'hEF};
        hi_b  = '{8'h00, 8'hAB, 8'h7F};
        yaw_e = '{16'h0001, 16'hABCD, 16'h7FEF};
        rst_n = 1'b0;
        INT   = 1'b0;
        done  = 1'b0;
        resp  = 16'h0000;
        tick();
        tick();
        chk("rst_snd", 16'(snd), 16'd0);
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_vld", 16'(vld), 16'd0);
        chk("rst_yaw", yaw_rt, 16'h0000);
        rst_n = 1'b1;

        pwrup_and_config("boot", 40);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("no_4th_snd", 16'(snd), 16'd0);
        end

        INT = 1'b1;
        tick();
        chk("int_lat1", 16'(snd), 16'd0);
        tick();
        chk("int_lat2", 16'(snd), 16'd0);
        tick();
        chk("int_lat3", 16'(snd), 16'd1);
        serve("rd1_lo", 16'hA600, 8'h34, 5, 1'b0);
        tick();
        chk("rd1_hi_snd", 16'(snd), 16'd1);
        INT = 1'b0;
        serve("rd1_hi", 16'hA700, 8'h12, 5, 1'b0);
        tick();
        chk("rd1_vld", 16'(vld), 16'd1);
        chk("rd1_yaw", yaw_rt, 16'h1234);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rd1_idle_vld", 16'(vld), 16'd0);
            chk("rd1_idle_snd", 16'(snd), 16'd0);
            chk("rd1_hold_yaw", yaw_rt, 16'h1234);
        end

        INT = 1'b1;
        wait_snd("rd2", 10);
        INT = 1'b0;
        serve("rd2_lo", 16'hA600, 8'h80, 3, 1'b0);
        tick();
        chk("rd2_hi_snd", 16'(snd), 16'd1);
        serve("rd2_hi", 16'hA700, 8'hFF, 3, 1'b0);
        tick();
        chk("rd2_vld", 16'(vld), 16'd1);
        chk("rd2_yaw", yaw_rt, 16'hFF80);
        for (int i = 0; i < 6; i++) tick();
        chk("rd2_idle_snd", 16'(snd), 16'd0);

        INT = 1'b1;
        wait_snd("held", 10);
        for (int p = 0; p < 3; p++) begin
            serve("held_lo", 16'hA600, lo_b[p], 4, 1'b0);
            tick();
            chk("held_hi_snd", 16'(snd), 16'd1);
            serve("held_hi", 16'hA700, hi_b[p], 4, 1'b0);
            tick();
            chk("held_vld", 16'(vld), 16'd1);
            chk("held_yaw", yaw_rt, yaw_e[p]);
            chk("held_vld_snd", 16'(snd), 16'd0);
            tick();
            chk("held_next_snd", 16'(snd), 16'd1);
            chk("held_next_cmd", cmd, 16'hA600);
            chk("held_next_vld", 16'(vld), 16'd0);
        end
        INT = 1'b0;
        serve("mid_lo", 16'hA600, 8'h55, 4, 1'b0);
        tick();
        chk("mid_hi_snd", 16'(snd), 16'd1);
        chk("mid_hi_cmd", cmd, 16'hA700);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_snd", 16'(snd), 16'd0);
        chk("mid_rst_cmd", cmd, 16'h0000);
        chk("mid_rst_vld", 16'(vld), 16'd0);
        chk("mid_rst_yaw", yaw_rt, 16'h0000);
        done = 1'b0;
        resp = 16'h0000;
        INT  = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        pwrup_and_config("reboot", 3);
        tick();
        chk("reboot_rd_snd", 16'(snd), 16'd1);
        chk("reboot_rd_cmd", cmd, 16'hA600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

endmodule

// File: doc/imu_yaw_reader.md
# imu_yaw_reader

Command sequencer upstream of the SPI monarch. After reset it waits for the inertial sensor to power up, issues a fixed configuration write sequence, then on every data-ready interrupt reads the yaw-rate low and high bytes. It presents the assembled 16-bit yaw rate to the heading logic with a one-cycle valid strobe. It drives the monarch's `snd`/`cmd` pair and consumes its `done`/`resp` pair.

## Interface
- `TMR_W`, default 16: power-up timer width. Config starts when the timer is all ones, i.e. 2^TMR_W cycles after reset. Benches use 4.
- `CFG0`, default 16'h0D02: first write, data-ready interrupt enable.
- `CFG1`, default 16'h1160: second write, gyro ODR/range.
- `CFG2`, default 16'h1440: third write, rounding enable.
- `RD_L`, default 16'hA600: yaw low-byte read command.
- `RD_H`, default 16'hA700: yaw high-byte read command.
- `clk`  in  1  system clock; all flops on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `INT`  in  1  sensor data-ready, asynchronous, level high.
- `done`  in  1  monarch transaction complete (level; cleared by monarch when it accepts `snd`).
- `resp`  in  16  monarch response; `resp[7:0]` is the read byte.
- `snd`  out  1  one-cycle request to monarch.
- `cmd`  out  16  command word, registered, stable from the `snd` cycle until completion.
- `yaw_rt`  out  16  signed yaw rate, {high byte, low byte}.
- `vld`  out  1  one-cycle strobe: `yaw_rt` freshly updated.

## Operation
- **INT synchronizer:** `INT` passes through two flops before any use (`int_s`).
- **Completion detect:** `done` is registered, and completion is the rising edge `done & ~done_q`. A level `done` left over from a prior transaction is never treated as completion.
- **Power-up timer:** TMR_W-bit counter that increments every cycle in `PWRUP` only. Reset value is 0.
- **States:**
  - `PWRUP`: when the timer is all ones, load `cmd=CFG0`, pulse `snd`, go to `W0`.
  - `W0`: on completion, load `CFG1`, pulse `snd`, go to `W1`.
  - `W1`: on completion, load `CFG2`, pulse `snd`, go to `W2`.
  - `W2`: on completion, go to `IDLE`.
  - `IDLE`: when `int_s`=1, load `RD_L`, pulse `snd`, go to `RL`.
  - `RL`: on completion, capture `resp[7:0]` into `yl`, load `RD_H`, pulse `snd`, go to `RH`.
  - `RH`: on completion, drive `yaw_rt <= {resp[7:0], yl}` and `vld <= 1` for one cycle, go to `IDLE`.
- **Interrupt level:** `INT` is level-sensitive. If `int_s` is still high on return to `IDLE`, a new read pair starts immediately. No interrupt edge is lost, because the sensor holds `INT` until it is read.
- **Ordering:** configuration writes are never repeated after reset. Reads are never issued before `W2` completes; `INT` is ignored in `PWRUP`/`W*`.
- **Stall:** no timeout. The FSM waits indefinitely for completion.
- **`snd` rules:** `snd` is high only in the single cycle `cmd` is loaded. It is never asserted while a transaction is outstanding.

## Timing
- **Reset values:** state `PWRUP`, timer 0, `snd`=0, `cmd`=16'h0000, `vld`=0, `yaw_rt`=16'h0000, `yl`=0, sync flops 0, `done_q`=0.
- **Reset mid-operation:** every output returns to its reset value asynchronously, and the full power-up and config sequence reruns.
- **First `snd`:** asserted in cycle 2^TMR_W after reset release, i.e. the cycle after the timer reads all ones.
- **Next command:** `snd` for the next command is asserted in the cycle after `done` is first sampled high (one cycle after the monarch raises `done`).
- **Read latency:**
  - `INT` rise to `snd` for `RD_L`: 3 cycles (2 sync + 1 registered output).
  - High-read `done` rise to `vld`: 1 cycle.
  - `yaw_rt` holds until the next `vld`.
- **Back-to-back:** minimum gap between `vld` and the next `RD_L` `snd` is 1 cycle, when `int_s` is still high.
- **Simultaneous completion and `INT` in `RH`:** `vld` is issued first. The new read starts from `IDLE` on the following cycle.

## Test plan
- **Reset/power-up:** TMR_W=4, hold `INT`=0 → `snd` first pulses at cycle 16 after reset with `cmd`=16'h0D02. Before that `snd`=0, `cmd`=0, `vld`=0.
- **Config sequence:** monarch model returns `done` 40 cycles after each `snd` → exactly three `snd` pulses with `cmd` 0D02, 1160, 1440, each one cycle after `done` rises. No fourth `snd` while `INT`=0.
- **Single read:** after config, raise `INT`; model returns resp 16'hxx34 then 16'hxx12 → `cmd` A600 then A700, then one `vld` with `yaw_rt`=16'h1234 (and 16'hFF80 for bytes 80/FF). Drop `INT` before the high read completes → FSM returns to `IDLE`.
- **Held INT:** keep `INT` high for three read pairs → three `vld` pulses, each followed by a new A600 `snd` one cycle later. `cmd` is never changed mid-transaction.
- **Stale done:** hold `done`=1 across a `snd` (model clears it a cycle late) → FSM does not advance until a fresh low→high transition.
- **Reset mid-read:** assert `rst_n` low during `RH` → `vld`/`snd`/`yaw_rt` go to 0 immediately. After release, the 16-cycle wait and full config rerun before any A600.
